spi_rf_coalesce: RTL
====================

// Module: spi_rf_coalesce
// PURPOSE
//  - APB register file for the next-generation SPI core. Parametrised APB width, slave-select count and clock-divider width.
//  - Adds rx-done interrupt coalescing: frame counter plus programmable threshold.
//  - Sits between the APB slave port and the SPI control/FIFO logic. Decodes CPU accesses and holds static configuration.
//  - Collects hardware status events into W1C interrupt flags and drives the single interrupt line.
// PARAMETERS
//  APB_DWIDTH  8    APB data width (8/16/32); registers occupy bits [7:0] unless noted, upper bits read 0
//  NUM_SSEL    8    slave-select outputs (1..16); SSEL register width
//  CLKDIV_W    8    clock-divider register width (8..16, <= APB_DWIDTH)
//  CFG_CLK     7    CLKDIV reset value
//  CNT_W       8    frame counter/threshold width (1..APB_DWIDTH)
//  TMO_W       16   rx timeout counter width (used only with SPI_RF_TIMEOUT_EN)
// PORTS
//  pclk          in   1           clock, all logic rising-edge
//  areset        in   1           asynchronous, active-high reset
//  paddr         in   7           APB byte address
//  psel,penable,pwrite in 1       APB strobes (zero-wait, no pready)
//  wrdata        in   APB_DWIDTH  write data;  prdata out APB_DWIDTH read data
//  interrupt     out  1           OR of masked interrupts
//  tx_done,rx_done,rx_channel_overflow,tx_channel_underflow,rx_cmdsize,rx_pktend in 1  one-cycle event pulses
//  tx_fifo_write,rx_fifo_read in 1  FIFO access pulses (clear sticky bits)
//  tx_fifo_full,rx_fifo_empty,first_frame,ssel,active in 1  level status
//  cfg_enable,cfg_master,cfg_frameurun,cfg_oenoff out 1  CTRL1 bits 0,1,6,7
//  cfg_cmdsize   out  3           CTRL2[2:0]
//  cfg_ssel      out  NUM_SSEL    SSEL register
//  clk_div_val   out  CLKDIV_W    CLKDIV register
//  clr_txfifo,clr_rxfifo out 1    one-cycle strobes
// BEHAVIOUR
//  - Reset: CTRL1=0, CTRL2=0, SSEL=0, CLKDIV=CFG_CLK, FRMTHR=1, FRMCNT=0, TIMEOUT=0, int_raw=8'h80, sticky=0, strobes=0.
//  - Writes commit on psel&pwrite&penable. Read is combinational: prdata = rdata when psel&penable, else 0.
//  - Map: 00 CTRL1 | 04 INTCLR (W1C, reads 0) | 10 MIS | 14 RIS | 18 CTRL2 | 1C CMD (wo) | 20 STATUS | 24 SSEL |
//    2C CLKDIV | 30 FRMTHR | 34 FRMCNT (ro) | 38 TIMEOUT. Unmapped addresses read 0; writes to them are ignored.
//  - Masks: MIS[0]=raw0&CTRL1[3], [1]=raw1&CTRL1[2], [2]=raw2&CTRL1[4], [3]=raw3&CTRL1[5], [7:4]=raw&CTRL2[7:4].
//  - Raw set sources:
//    - [0] tx_done, [1] coalesced rx (below), [2] rx_channel_overflow, [3] tx_channel_underflow.
//    - [4] rx_cmdsize, [5] rx_pktend, [6] !rx_fifo_empty, [7] !tx_fifo_full.
//  - Same-cycle hardware set and INTCLR clear of one bit: set wins. Levels [7:6] re-set on the next cycle if still true.
//  - CMD write: [0] pulses clr_rxfifo, [1] pulses clr_txfifo. Each strobe is high exactly 1 cycle after the write, then 0.
//  - CMD write [2] clears FRMCNT.
//  - STATUS = {active, ssel, raw3, raw2, tx_fifo_full, rx_fifo_empty, sticky_tx&sticky_rx, first_frame}.
//  - Sticky: tx_done sets sticky_tx, tx_fifo_write clears it; rx_done sets sticky_rx, rx_fifo_read clears it.
//    Same cycle: clear wins.
//  - Coalescing: effective threshold THR = (FRMTHR==0) ? 1 : FRMTHR.
//    - On rx_done: if FRMCNT+1 >= THR, set raw1 and FRMCNT<=0; else FRMCNT<=FRMCNT+1.
//    - No wrap: the compare is width CNT_W+1.
//    - FRMTHR lowered below FRMCNT: the next rx_done fires and resets FRMCNT.
//    - CMD[2] in the same cycle as rx_done: clear wins, FRMCNT=0, no raw1 set.
//  - SSEL/CLKDIV/FRMTHR writes truncate wrdata to register width.
// CONFIGURATION
//  SPI_RF_TIMEOUT_EN defined:
//    - TIMEOUT register (TMO_W bits) present at 0x38.
//    - Timer increments each pclk while cfg_enable & !rx_fifo_empty & TIMEOUT!=0.
//    - Timer resets to 0 on rx_done, rx_fifo_read, rx_fifo_empty or a TIMEOUT write.
//    - On reaching TIMEOUT: set raw1, clear FRMCNT, hold the timer (fires once) until the next reset condition.
//    - Coalesced fire and timeout fire in the same cycle give a single raw1 set; FRMCNT=0.
//  SPI_RF_TIMEOUT_EN undefined: no timer logic; 0x38 reads 0 and ignores writes; raw1 comes from coalescing only.
// TESTING
//  1. Reset -> RIS=0x80, CLKDIV=7, FRMTHR=1, interrupt=0; write CTRL2=0x80 -> interrupt=1 next cycle.
//  2. FRMTHR=3, CTRL1=0x04, 5 rx_done pulses -> raw1 set after the 3rd only, FRMCNT=2; INTCLR 0x02 -> interrupt=0.
//  3. INTCLR 0x01 in the same cycle as tx_done -> RIS[0] stays 1; CMD=0x03 -> clr_rxfifo,clr_txfifo high 1 cycle.
//  4. FRMCNT=2, CMD=0x04 together with rx_done -> FRMCNT=0, RIS[1]=0; FRMTHR=0 -> every rx_done sets RIS[1].
//  5. TIMEOUT_EN: TIMEOUT=10, FRMTHR=8, enable, rx_fifo_empty=0 after 1 frame -> RIS[1] set exactly 10 cycles later.
//     Then FRMCNT=0, no second fire while held.
//  6. Assert areset mid-count (FRMCNT=5, timer=4) -> all registers return to reset values asynchronously; prdata=0.

Source files
------------

// File: rtl/spi_rf_coalesce.sv
// APB register file for the SPI core with rx-done interrupt coalescing.
// Optional rx timeout timer enabled by defining SPI_RF_TIMEOUT_EN.
module spi_rf_coalesce #(
  parameter int unsigned APB_DWIDTH = 8,
  parameter int unsigned NUM_SSEL   = 8,
  parameter int unsigned CLKDIV_W   = 8,
  parameter int unsigned CFG_CLK    = 7,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned TMO_W      = 16
) (
  input  logic                  pclk,
  input  logic                  areset,
  input  logic [6:0]            paddr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [APB_DWIDTH-1:0] wrdata,
  output logic [APB_DWIDTH-1:0] prdata,
  output logic                  interrupt,
  input  logic                  tx_done,
  input  logic                  rx_done,
  input  logic                  rx_channel_overflow,
  input  logic                  tx_channel_underflow,
  input  logic                  rx_cmdsize,
  input  logic                  rx_pktend,
  input  logic                  tx_fifo_write,
  input  logic                  rx_fifo_read,
  input  logic                  tx_fifo_full,
  input  logic                  rx_fifo_empty,
  input  logic                  first_frame,
  input  logic                  ssel,
  input  logic                  active,
  output logic                  cfg_enable,
  output logic                  cfg_master,
  output logic                  cfg_frameurun,
  output logic                  cfg_oenoff,
  output logic [2:0]            cfg_cmdsize,
  output logic [NUM_SSEL-1:0]   cfg_ssel,
  output logic [CLKDIV_W-1:0]   clk_div_val,
  output logic                  clr_txfifo,
  output logic                  clr_rxfifo
);

  localparam logic [6:0] AddrCtrl1  = 7'h00;
  localparam logic [6:0] AddrIntClr = 7'h04;
  localparam logic [6:0] AddrMis    = 7'h10;
  localparam logic [6:0] AddrRis    = 7'h14;
  localparam logic [6:0] AddrCtrl2  = 7'h18;
  localparam logic [6:0] AddrCmd    = 7'h1C;
  localparam logic [6:0] AddrStatus = 7'h20;
  localparam logic [6:0] AddrSsel   = 7'h24;
  localparam logic [6:0] AddrClkDiv = 7'h2C;
  localparam logic [6:0] AddrFrmThr = 7'h30;
  localparam logic [6:0] AddrFrmCnt = 7'h34;
  localparam logic [6:0] AddrTmo    = 7'h38;

  if (CNT_W < 1 || CNT_W > APB_DWIDTH || CLKDIV_W > APB_DWIDTH || TMO_W < 1) begin : g_bad_cfg
    $error("spi_rf_coalesce: illegal parameter combination");
  end

  logic                wr_en;
  logic [7:0]          wr_byte;
  logic [7:0]          ctrl1_q, ctrl2_q, int_raw_q, int_raw_d, int_set, int_clr, mis;
  logic [NUM_SSEL-1:0] ssel_q;
  logic [CLKDIV_W-1:0] clkdiv_q;
  logic [CNT_W-1:0]    frmthr_q, frmcnt_q, frmcnt_d;
  logic [CNT_W:0]      cnt_inc, thr_eff;
  logic                sticky_tx_q, sticky_rx_q;
  logic                clr_txfifo_q, clr_rxfifo_q;
  logic                coal_fire, tmo_fire, cnt_clr;
  logic [APB_DWIDTH-1:0] rdata;

  assign wr_en   = psel & penable & pwrite;
  assign wr_byte = 8'(wrdata);
  assign cnt_clr = wr_en && (paddr == AddrCmd) && wr_byte[2];

  // Threshold of zero behaves as one; compare is one bit wider so it never wraps.
  assign cnt_inc = {1'b0, frmcnt_q} + 1'b1;
  assign thr_eff = (frmthr_q == '0) ? (CNT_W + 1)'(1) : {1'b0, frmthr_q};

`ifdef SPI_RF_TIMEOUT_EN
  logic [TMO_W-1:0] timeout_q, timer_q, timer_d;
  logic             wr_tmo;

  assign wr_tmo = wr_en && (paddr == AddrTmo);

  // Timer stops once it reaches TIMEOUT so it fires only once per idle period.
  always_comb begin
    timer_d  = timer_q;
    tmo_fire = 1'b0;
    if (rx_done || rx_fifo_read || rx_fifo_empty || wr_tmo) begin
      timer_d = '0;
    end else if (ctrl1_q[0] && (timeout_q != '0) && (timer_q != timeout_q)) begin
      timer_d  = timer_q + 1'b1;
      tmo_fire = (timer_d == timeout_q);
    end
  end

  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      timeout_q <= '0;
      timer_q   <= '0;
    end else begin
      timer_q <= timer_d;
      if (wr_tmo) timeout_q <= TMO_W'(wrdata);
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_comb begin
    frmcnt_d  = frmcnt_q;
    coal_fire = 1'b0;
    if (cnt_clr) begin
      frmcnt_d = '0;
    end else if (rx_done) begin
      if (cnt_inc >= thr_eff) begin
        coal_fire = 1'b1;
        frmcnt_d  = '0;
      end else begin
        frmcnt_d = cnt_inc[CNT_W-1:0];
      end
    end
    if (tmo_fire) frmcnt_d = '0;
  end

  assign int_set = {~tx_fifo_full, ~rx_fifo_empty, rx_pktend, rx_cmdsize,
                    tx_channel_underflow, rx_channel_overflow, coal_fire | tmo_fire, tx_done};
  assign int_clr = (wr_en && (paddr == AddrIntClr)) ? wr_byte : 8'h00;
  assign int_raw_d = (int_raw_q & ~int_clr) | int_set;

  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      ctrl1_q      <= 8'h00;
      ctrl2_q      <= 8'h00;
      ssel_q       <= '0;
      clkdiv_q     <= CLKDIV_W'(CFG_CLK);
      frmthr_q     <= CNT_W'(1);
      frmcnt_q     <= '0;
      int_raw_q    <= 8'h80;
      sticky_tx_q  <= 1'b0;
      sticky_rx_q  <= 1'b0;
      clr_txfifo_q <= 1'b0;
      clr_rxfifo_q <= 1'b0;
    end else begin
      frmcnt_q     <= frmcnt_d;
      int_raw_q    <= int_raw_d;
      clr_rxfifo_q <= wr_en && (paddr == AddrCmd) && wr_byte[0];
      clr_txfifo_q <= wr_en && (paddr == AddrCmd) && wr_byte[1];
      if (tx_fifo_write)     sticky_tx_q <= 1'b0;
      else if (tx_done)      sticky_tx_q <= 1'b1;
      if (rx_fifo_read)      sticky_rx_q <= 1'b0;
      else if (rx_done)      sticky_rx_q <= 1'b1;
      if (wr_en) begin
        case (paddr)
          AddrCtrl1:  ctrl1_q  <= wr_byte;
          AddrCtrl2:  ctrl2_q  <= wr_byte;
          AddrSsel:   ssel_q   <= NUM_SSEL'(wrdata);
          AddrClkDiv: clkdiv_q <= CLKDIV_W'(wrdata);
          AddrFrmThr: frmthr_q <= CNT_W'(wrdata);
          default: ;
        endcase
      end
    end
  end

  assign mis = {int_raw_q[7:4] & ctrl2_q[7:4],
                int_raw_q[3] & ctrl1_q[5], int_raw_q[2] & ctrl1_q[4],
                int_raw_q[1] & ctrl1_q[2], int_raw_q[0] & ctrl1_q[3]};

  always_comb begin
    rdata = '0;
    case (paddr)
      AddrCtrl1:  rdata = APB_DWIDTH'(ctrl1_q);
      AddrMis:    rdata = APB_DWIDTH'(mis);
      AddrRis:    rdata = APB_DWIDTH'(int_raw_q);
      AddrCtrl2:  rdata = APB_DWIDTH'(ctrl2_q);
      AddrStatus: rdata = APB_DWIDTH'({active, ssel, int_raw_q[3], int_raw_q[2], tx_fifo_full,
                                       rx_fifo_empty, sticky_tx_q & sticky_rx_q, first_frame});
      AddrSsel:   rdata = APB_DWIDTH'(ssel_q);
      AddrClkDiv: rdata = APB_DWIDTH'(clkdiv_q);
      AddrFrmThr: rdata = APB_DWIDTH'(frmthr_q);
      AddrFrmCnt: rdata = APB_DWIDTH'(frmcnt_q);
`ifdef SPI_RF_TIMEOUT_EN
      AddrTmo:    rdata = APB_DWIDTH'(timeout_q);
`endif
      default:    rdata = '0;
    endcase
  end

  assign prdata        = (psel & penable) ? rdata : '0;
  assign interrupt     = |mis;
  assign cfg_enable    = ctrl1_q[0];
  assign cfg_master    = ctrl1_q[1];
  assign cfg_frameurun = ctrl1_q[6];
  assign cfg_oenoff    = ctrl1_q[7];
  assign cfg_cmdsize   = ctrl2_q[2:0];
  assign cfg_ssel      = ssel_q;
  assign clk_div_val   = clkdiv_q;
  assign clr_txfifo    = clr_txfifo_q;
  assign clr_rxfifo    = clr_rxfifo_q;

endmodule
